// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
// Build option: SCB_FWD_EN (forwarded results usable in their final cycle).
package issue_scoreboard_pkg;

  localparam int SB_NUM_REGS = 128;
  localparam int SB_ADDR_W   = 7;
  localparam int SB_LAT_W    = 3;
  localparam int SB_LAT_MAX  = 7;

  typedef enum logic {
    SB_PAIR,
    SB_SPLIT
  } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_hazard_chk.sv
// Per-slot hazard check: RAW, WAW and optional in-pair dependency.
// Build option: SCB_FWD_EN relaxes the RAW pending test.
module scb_hazard_chk
  import issue_scoreboard_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int LAT_W  = SB_LAT_W
) (
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rc_addr,
  input  logic              ra_use,
  input  logic              rb_use,
  input  logic              rc_use,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rt_we,
  input  logic [LAT_W-1:0]  lat,
  input  logic [LAT_W-1:0]  ra_cnt,
  input  logic [LAT_W-1:0]  rb_cnt,
  input  logic [LAT_W-1:0]  rc_cnt,
  input  logic [LAT_W-1:0]  rt_cnt,
  input  logic              pair_en,
  input  logic [ADDR_W-1:0] prt_addr,
  input  logic              prt_we,
  output logic              hazard
);

  function automatic logic pend(input logic [LAT_W-1:0] c);
`ifdef SCB_FWD_EN
    return c > LAT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  logic [LAT_W-1:0] lat_e;
  logic             src_haz;
  logic             waw_haz;
  logic             pair_haz;

  always_comb begin
    lat_e   = (lat == '0) ? LAT_W'(1) : lat;
    src_haz = (ra_use && pend(ra_cnt))
            | (rb_use && pend(rb_cnt))
            | (rc_use && pend(rc_cnt));
    waw_haz = rt_we && (rt_cnt > lat_e);
    pair_haz = pair_en && prt_we &&
               ((ra_use && ra_addr == prt_addr)
              | (rb_use && rb_addr == prt_addr)
              | (rc_use && rc_addr == prt_addr)
              | (rt_we  && rt_addr == prt_addr));
    hazard = src_haz | waw_haz | pair_haz;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and in-order dual-issue gate for the even/odd pipes.
// Build option: SCB_FWD_EN (see scb_hazard_chk).
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int ADDR_W   = SB_ADDR_W,
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] ra_addr_ep,
  input  logic [ADDR_W-1:0] rb_addr_ep,
  input  logic [ADDR_W-1:0] rc_addr_ep,
  input  logic [ADDR_W-1:0] rt_addr_ep,
  input  logic [ADDR_W-1:0] ra_addr_op,
  input  logic [ADDR_W-1:0] rb_addr_op,
  input  logic [ADDR_W-1:0] rc_addr_op,
  input  logic [ADDR_W-1:0] rt_addr_op,
  input  logic              ra_use_ep,
  input  logic              rb_use_ep,
  input  logic              rc_use_ep,
  input  logic              ra_use_op,
  input  logic              rb_use_op,
  input  logic              rc_use_op,
  input  logic              rt_we_ep,
  input  logic              rt_we_op,
  input  logic [LAT_W-1:0]  lat_ep,
  input  logic [LAT_W-1:0]  lat_op,
  output logic              issue_ep,
  output logic              issue_op,
  output logic              dec_hold,
  output logic              sb_busy
);

  logic [LAT_W-1:0] cnt     [NUM_REGS];
  logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
  logic             busy_nxt;
  sb_state_t        state;
  sb_state_t        state_nxt;
  logic             haz_ep;
  logic             haz_op;
  logic [LAT_W-1:0] lat_ep_e;
  logic [LAT_W-1:0] lat_op_e;

  scb_hazard_chk #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) u_chk_ep (
    .ra_addr  (ra_addr_ep),
    .rb_addr  (rb_addr_ep),
    .rc_addr  (rc_addr_ep),
    .ra_use   (ra_use_ep),
    .rb_use   (rb_use_ep),
    .rc_use   (rc_use_ep),
    .rt_addr  (rt_addr_ep),
    .rt_we    (rt_we_ep),
    .lat      (lat_ep),
    .ra_cnt   (cnt[ra_addr_ep]),
    .rb_cnt   (cnt[rb_addr_ep]),
    .rc_cnt   (cnt[rc_addr_ep]),
    .rt_cnt   (cnt[rt_addr_ep]),
    .pair_en  (1'b0),
    .prt_addr ('0),
    .prt_we   (1'b0),
    .hazard   (haz_ep)
  );

  // In SPLIT the even write already sits in cnt, so the pair check is off.
  scb_hazard_chk #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) u_chk_op (
    .ra_addr  (ra_addr_op),
    .rb_addr  (rb_addr_op),
    .rc_addr  (rc_addr_op),
    .ra_use   (ra_use_op),
    .rb_use   (rb_use_op),
    .rc_use   (rc_use_op),
    .rt_addr  (rt_addr_op),
    .rt_we    (rt_we_op),
    .lat      (lat_op),
    .ra_cnt   (cnt[ra_addr_op]),
    .rb_cnt   (cnt[rb_addr_op]),
    .rc_cnt   (cnt[rc_addr_op]),
    .rt_cnt   (cnt[rt_addr_op]),
    .pair_en  (state == SB_PAIR),
    .prt_addr (rt_addr_ep),
    .prt_we   (rt_we_ep),
    .hazard   (haz_op)
  );

  always_comb begin
    issue_ep  = 1'b0;
    issue_op  = 1'b0;
    dec_hold  = 1'b0;
    state_nxt = state;
    if (rst) begin
      state_nxt = SB_PAIR;
    end else if (flush) begin
      state_nxt = SB_PAIR;
    end else if (dec_valid) begin
      unique case (state)
        SB_PAIR: begin
          if (haz_ep) begin
            dec_hold = 1'b1;
          end else if (haz_op) begin
            issue_ep  = 1'b1;
            dec_hold  = 1'b1;
            state_nxt = SB_SPLIT;
          end else begin
            issue_ep = 1'b1;
            issue_op = 1'b1;
          end
        end
        SB_SPLIT: begin
          if (haz_op) begin
            dec_hold = 1'b1;
          end else begin
            issue_op  = 1'b1;
            state_nxt = SB_PAIR;
          end
        end
        default: state_nxt = SB_PAIR;
      endcase
    end
  end

  always_comb begin
    lat_ep_e = (lat_ep == '0) ? LAT_W'(1) : lat_ep;
    lat_op_e = (lat_op == '0) ? LAT_W'(1) : lat_op;
    busy_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_ep && rt_we_ep && rt_addr_ep == ADDR_W'(r)) begin
        cnt_nxt[r] = lat_ep_e;
      end else if (issue_op && rt_we_op && rt_addr_op == ADDR_W'(r)) begin
        cnt_nxt[r] = lat_op_e;
      end else if (cnt[r] != '0) begin
        cnt_nxt[r] = cnt[r] - LAT_W'(1);
      end else begin
        cnt_nxt[r] = cnt[r];
      end
      busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SB_PAIR;
      sb_busy <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      state   <= state_nxt;
      sb_busy <= busy_nxt;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard.
// Honors SCB_FWD_EN when selecting expected stall lengths.
module tb_issue_scoreboard;

`ifdef SCB_FWD_EN
  localparam int RAW6_HOLD  = 5;
  localparam int SPLIT_HOLD = 2;
`else
  localparam int RAW6_HOLD  = 6;
  localparam int SPLIT_HOLD = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       dec_valid;
  logic [6:0] ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [6:0] ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic       ra_use_ep, rb_use_ep, rc_use_ep;
  logic       ra_use_op, rb_use_op, rc_use_op;
  logic       rt_we_ep, rt_we_op;
  logic [2:0] lat_ep, lat_op;
  logic       issue_ep, issue_op, dec_hold, sb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid),
    .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep),
    .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op),
    .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
    .ra_use_ep(ra_use_ep), .rb_use_ep(rb_use_ep), .rc_use_ep(rc_use_ep),
    .ra_use_op(ra_use_op), .rb_use_op(rb_use_op), .rc_use_op(rc_use_op),
    .rt_we_ep(rt_we_ep), .rt_we_op(rt_we_op),
    .lat_ep(lat_ep), .lat_op(lat_op),
    .issue_ep(issue_ep), .issue_op(issue_op),
    .dec_hold(dec_hold), .sb_busy(sb_busy)
  );

  task automatic clr();
    dec_valid = 0;
    ra_addr_ep = 0; rb_addr_ep = 0; rc_addr_ep = 0; rt_addr_ep = 0;
    ra_addr_op = 0; rb_addr_op = 0; rc_addr_op = 0; rt_addr_op = 0;
    ra_use_ep = 0; rb_use_ep = 0; rc_use_ep = 0;
    ra_use_op = 0; rb_use_op = 0; rc_use_op = 0;
    rt_we_ep = 0; rt_we_op = 0; lat_ep = 0; lat_op = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; flush = 0; clr();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; clr(); dec_valid = 1;
    ra_addr_ep = 1; ra_use_ep = 1; rt_addr_ep = 2; rt_we_ep = 1; lat_ep = 3;
    #1;
    checks++; if (issue_ep !== 1'b0) begin errors++; $display("FAIL rst_issue_ep got=%b exp=0", issue_ep); end
    checks++; if (issue_op !== 1'b0) begin errors++; $display("FAIL rst_issue_op got=%b exp=0", issue_op); end
    checks++; if (dec_hold !== 1'b0) begin errors++; $display("FAIL rst_dec_hold got=%b exp=0", dec_hold); end
    @(negedge clk); rst = 0; clr(); #1;
    checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL rst_sb_busy got=%b exp=0", sb_busy); end
  endtask

  task automatic test_clean();
    @(negedge clk);
    clr(); dec_valid = 1;
    ra_addr_ep = 1; ra_use_ep = 1; rt_addr_ep = 2; rt_we_ep = 1; lat_ep = 3;
    ra_addr_op = 4; ra_use_op = 1; rt_addr_op = 5; rt_we_op = 1; lat_op = 2;
    #1;
    checks++; if (issue_ep !== 1'b1) begin errors++; $display("FAIL clean_issue_ep got=%b exp=1", issue_ep); end
    checks++; if (issue_op !== 1'b1) begin errors++; $display("FAIL clean_issue_op got=%b exp=1", issue_op); end
    checks++; if (dec_hold !== 1'b0) begin errors++; $display("FAIL clean_dec_hold got=%b exp=0", dec_hold); end
    @(negedge clk); clr(); #1;
    checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL clean_sb_busy got=%b exp=1", sb_busy); end
    do_reset();
  endtask

  task automatic test_raw();
    int  holds;
    bit  done;
    bit  hold_ok;
    @(negedge clk);
    clr(); dec_valid = 1; rt_addr_ep = 5; rt_we_ep = 1; lat_ep = 6;
    #1;
    checks++; if (issue_ep !== 1'b1) begin errors++; $display("FAIL raw_producer got=%b exp=1", issue_ep); end
    @(negedge clk);
    clr(); dec_valid = 1; ra_addr_ep = 5; ra_use_ep = 1;
    holds = 0; done = 0; hold_ok = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (issue_ep === 1'b1) begin done = 1; break; end
      if (dec_hold !== 1'b1) hold_ok = 0;
      holds++;
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL raw_timeout got=noissue exp=issue"); end
    checks++; if (holds != RAW6_HOLD) begin errors++; $display("FAIL raw_holds got=%0d exp=%0d", holds, RAW6_HOLD); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL raw_hold_asserted got=0 exp=1"); end
    checks++; if (issue_op !== 1'b1 || dec_hold !== 1'b0) begin
      errors++; $display("FAIL raw_release got=op%b/hold%b exp=op1/hold0", issue_op, dec_hold);
    end
    do_reset();
  endtask

  task automatic test_split();
    int holds;
    bit done;
    bit ep_quiet;
    @(negedge clk);
    clr(); dec_valid = 1;
    rt_addr_ep = 3; rt_we_ep = 1; lat_ep = 3;
    ra_addr_op = 3; ra_use_op = 1;
    #1;
    checks++; if (issue_ep !== 1'b1) begin errors++; $display("FAIL split_ep got=%b exp=1", issue_ep); end
    checks++; if (issue_op !== 1'b0) begin errors++; $display("FAIL split_op0 got=%b exp=0", issue_op); end
    checks++; if (dec_hold !== 1'b1) begin errors++; $display("FAIL split_hold0 got=%b exp=1", dec_hold); end
    @(negedge clk);
    holds = 0; done = 0; ep_quiet = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (issue_ep !== 1'b0) ep_quiet = 0;
      if (issue_op === 1'b1) begin done = 1; break; end
      holds++;
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL split_timeout got=noissue exp=issue"); end
    checks++; if (holds != SPLIT_HOLD) begin errors++; $display("FAIL split_holds got=%0d exp=%0d", holds, SPLIT_HOLD); end
    checks++; if (!ep_quiet) begin errors++; $display("FAIL split_ep_reissue got=1 exp=0"); end
    checks++; if (dec_hold !== 1'b0) begin errors++; $display("FAIL split_release got=%b exp=0", dec_hold); end
    @(negedge clk);
    clr(); dec_valid = 1;
    rt_addr_ep = 7; rt_we_ep = 1; lat_ep = 1;
    rt_addr_op = 7; rt_we_op = 1; lat_op = 1;
    #1;
    checks++; if (issue_ep !== 1'b1 || issue_op !== 1'b0) begin
      errors++; $display("FAIL samert_split got=ep%b/op%b exp=ep1/op0", issue_ep, issue_op);
    end
    @(negedge clk); #1;
    checks++; if (issue_op !== 1'b1 || dec_hold !== 1'b0) begin
      errors++; $display("FAIL samert_odd got=op%b/hold%b exp=op1/hold0", issue_op, dec_hold);
    end
    do_reset();
  endtask

  task automatic test_waw();
    int holds;
    bit done;
    @(negedge clk);
    clr(); dec_valid = 1; rt_addr_ep = 9; rt_we_ep = 1; lat_ep = 5;
    #1;
    checks++; if (issue_ep !== 1'b1) begin errors++; $display("FAIL waw_first got=%b exp=1", issue_ep); end
    @(negedge clk);
    clr(); dec_valid = 1; rt_addr_ep = 9; rt_we_ep = 1; lat_ep = 2;
    holds = 0; done = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (issue_ep === 1'b1) begin done = 1; break; end
      holds++;
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL waw_timeout got=noissue exp=issue"); end
    checks++; if (holds != 3) begin errors++; $display("FAIL waw_holds got=%0d exp=3", holds); end
    do_reset();
    @(negedge clk);
    clr(); dec_valid = 1; rt_addr_ep = 20; rt_we_ep = 1; lat_ep = 0;
    @(negedge clk); clr(); #1;
    checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL lat0_busy got=%b exp=1", sb_busy); end
    @(negedge clk); #1;
    checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL lat0_idle got=%b exp=0", sb_busy); end
    do_reset();
  endtask

  task automatic test_flush();
    @(negedge clk);
    clr(); dec_valid = 1;
    rt_addr_ep = 3; rt_we_ep = 1; lat_ep = 4;
    ra_addr_op = 3; ra_use_op = 1;
    #1;
    checks++; if (issue_ep !== 1'b1 || dec_hold !== 1'b1) begin
      errors++; $display("FAIL flush_setup got=ep%b/hold%b exp=ep1/hold1", issue_ep, dec_hold);
    end
    @(negedge clk); flush = 1; #1;
    checks++; if (issue_op !== 1'b0) begin errors++; $display("FAIL flush_op got=%b exp=0", issue_op); end
    checks++; if (issue_ep !== 1'b0) begin errors++; $display("FAIL flush_ep got=%b exp=0", issue_ep); end
    @(negedge clk);
    flush = 0; clr(); dec_valid = 1;
    ra_addr_ep = 10; ra_use_ep = 1; ra_addr_op = 11; ra_use_op = 1;
    #1;
    checks++; if (issue_ep !== 1'b1 || issue_op !== 1'b1) begin
      errors++; $display("FAIL flush_pair got=ep%b/op%b exp=ep1/op1", issue_ep, issue_op);
    end
    checks++; if (sb_busy !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b exp=1", sb_busy); end
    @(negedge clk);
    clr(); dec_valid = 1; ra_addr_ep = 3; ra_use_ep = 1;
    #1;
    checks++; if (dec_hold !== 1'b1 || issue_ep !== 1'b0) begin
      errors++; $display("FAIL flush_cnt_kept got=hold%b/ep%b exp=hold1/ep0", dec_hold, issue_ep);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clr(); dec_valid = 1;
    rt_addr_ep = 5; rt_we_ep = 1; lat_ep = 7;
    ra_addr_op = 5; ra_use_op = 1;
    #1;
    checks++; if (issue_ep !== 1'b1 || issue_op !== 1'b0) begin
      errors++; $display("FAIL rmid_setup got=ep%b/op%b exp=ep1/op0", issue_ep, issue_op);
    end
    @(negedge clk); rst = 1; #1;
    checks++; if (issue_op !== 1'b0 || dec_hold !== 1'b0) begin
      errors++; $display("FAIL rmid_in_rst got=op%b/hold%b exp=op0/hold0", issue_op, dec_hold);
    end
    @(negedge clk);
    rst = 0; clr(); dec_valid = 1;
    ra_addr_ep = 5; ra_use_ep = 1; rb_addr_op = 5; rb_use_op = 1;
    #1;
    checks++; if (sb_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", sb_busy); end
    checks++; if (issue_ep !== 1'b1 || issue_op !== 1'b1) begin
      errors++; $display("FAIL rmid_pair got=ep%b/op%b exp=ep1/op1", issue_ep, issue_op);
    end
    checks++; if (dec_hold !== 1'b0) begin errors++; $display("FAIL rmid_hold got=%b exp=0", dec_hold); end
  endtask

  initial begin
    clr();
    do_reset();
    test_reset();
    test_clean();
    test_raw();
    test_split();
    test_waw();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
